// File: rtl/timer_output_stage_pkg.sv
// Shared mode encodings and action decode for the timer output stage.
// Each mode maps to an action on threshold match and an action at period end.
package timer_output_pkg;

  localparam logic [2:0] OUT_SET     = 3'b000;
  localparam logic [2:0] OUT_TOG_CLR = 3'b001;
  localparam logic [2:0] OUT_SET_CLR = 3'b010;
  localparam logic [2:0] OUT_TOG     = 3'b011;
  localparam logic [2:0] OUT_CLR     = 3'b100;
  localparam logic [2:0] OUT_TOG_SET = 3'b101;
  localparam logic [2:0] OUT_CLR_SET = 3'b110;
  localparam logic [2:0] OUT_RSVD    = 3'b111;

  typedef enum logic [1:0] {
    ACT_NONE = 2'd0,
    ACT_SET  = 2'd1,
    ACT_CLR  = 2'd2,
    ACT_TOG  = 2'd3
  } act_e;

  typedef struct packed {
    act_e on_match;
    act_e on_end;
  } act_pair_t;

  function automatic act_pair_t decode_mode(input logic [2:0] mode);
    act_pair_t a;
    a.on_match = ACT_NONE;
    a.on_end   = ACT_NONE;
    case (mode)
      OUT_SET:     a.on_match = ACT_SET;
      OUT_TOG_CLR: begin a.on_match = ACT_TOG; a.on_end = ACT_CLR; end
      OUT_SET_CLR: begin a.on_match = ACT_SET; a.on_end = ACT_CLR; end
      OUT_TOG:     a.on_match = ACT_TOG;
      OUT_CLR:     a.on_match = ACT_CLR;
      OUT_TOG_SET: begin a.on_match = ACT_TOG; a.on_end = ACT_SET; end
      OUT_CLR_SET: begin a.on_match = ACT_CLR; a.on_end = ACT_SET; end
      default:     a = '{on_match: ACT_NONE, on_end: ACT_NONE};
    endcase
    return a;
  endfunction

  function automatic logic apply_act(input act_e act, input logic v);
    logic r;
    case (act)
      ACT_SET: r = 1'b1;
      ACT_CLR: r = 1'b0;
      ACT_TOG: r = ~v;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_output_stage_if.sv
// Counter/config side to output-pin side bundle of the timer output stage.
// The master drives counter state and config; the slave (output stage) drives the pins.
interface timer_output_stage_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) ();

  logic                    ctrl_active_i;
  logic                    ctrl_update_i;
  logic                    ctrl_rst_i;
  logic [CNT_W-1:0]        cnt_i;
  logic                    cnt_evt_i;
  logic                    cnt_end_i;
  logic [NUM_CH*CNT_W-1:0] cfg_th_i;
  logic [NUM_CH*3-1:0]     cfg_mode_i;
  logic [NUM_CH-1:0]       out_o;
  logic [NUM_CH-1:0]       out_evt_o;

  modport master (
    output ctrl_active_i, ctrl_update_i, ctrl_rst_i,
    output cnt_i, cnt_evt_i, cnt_end_i, cfg_th_i, cfg_mode_i,
    input  out_o, out_evt_o
  );

  modport slave (
    input  ctrl_active_i, ctrl_update_i, ctrl_rst_i,
    input  cnt_i, cnt_evt_i, cnt_end_i, cfg_th_i, cfg_mode_i,
    output out_o, out_evt_o
  );

endinterface

// File: rtl/timer_output_stage_ch.sv
// One output channel: shadowed threshold/mode, equality compare, match-then-end
// action resolution, and the registered output with its change pulse.
module timer_output_ch
  import timer_output_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             active,
  input  logic             update,
  input  logic             ctrl_rst,
  input  logic [CNT_W-1:0] cnt,
  input  logic             cnt_evt,
  input  logic             cnt_end,
  input  logic [CNT_W-1:0] cfg_th,
  input  logic [2:0]       cfg_mode,
  output logic             out,
  output logic             out_evt
);

  logic [CNT_W-1:0] th_q;
  logic [2:0]       mode_q;
  act_pair_t        acts;
  logic             qual;
  logic             hit;
  logic             out_nxt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      th_q   <= '0;
      mode_q <= OUT_SET;
    end else if (update) begin
      th_q   <= cfg_th;
      mode_q <= cfg_mode;
    end
  end

  // End action is applied after the match action so it wins when both fire.
  always_comb begin
    acts    = decode_mode(mode_q);
    qual    = active & cnt_evt;
    hit     = (cnt == th_q);
    out_nxt = out;
    if (qual) begin
      if (hit)     out_nxt = apply_act(acts.on_match, out_nxt);
      if (cnt_end) out_nxt = apply_act(acts.on_end, out_nxt);
    end
    if (ctrl_rst) out_nxt = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out     <= 1'b0;
      out_evt <= 1'b0;
    end else begin
      out     <= out_nxt;
      out_evt <= out_nxt ^ out;
    end
  end

endmodule

// File: rtl/timer_output_stage.sv
// Timer output stage top: one independent compare/output channel per slice
// of the packed threshold and mode buses.
module timer_output_stage
  import timer_output_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  timer_output_stage_if.slave bus
);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    timer_output_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .active   (bus.ctrl_active_i),
      .update   (bus.ctrl_update_i),
      .ctrl_rst (bus.ctrl_rst_i),
      .cnt      (bus.cnt_i),
      .cnt_evt  (bus.cnt_evt_i),
      .cnt_end  (bus.cnt_end_i),
      .cfg_th   (bus.cfg_th_i[k*CNT_W +: CNT_W]),
      .cfg_mode (bus.cfg_mode_i[k*3 +: 3]),
      .out      (bus.out_o[k]),
      .out_evt  (bus.out_evt_o[k])
    );
  end

endmodule

// File: tb/tb_timer_output_stage.sv
// Bench for timer_output_stage: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a table-driven model.
module tb_timer_output_stage;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;

  logic clk_i = 1'b0;
  logic rstn_i;

  timer_output_stage_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  timer_output_stage #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // Action codes: 0 none, 1 set, 2 clear, 3 toggle; indexed by mode value.
  int match_tbl [8] = '{1, 3, 1, 3, 2, 3, 2, 0};
  int end_tbl   [8] = '{0, 2, 2, 0, 0, 1, 1, 0};

  bit [NUM_CH-1:0] m_out;
  bit [NUM_CH-1:0] m_evt;
  int              m_th   [NUM_CH];
  int              m_mode [NUM_CH];

  int n_tests = 0;
  int n_fail  = 0;
  int ev0     = 0;

  function automatic bit do_act(input int a, input bit v);
    if (a == 1) return 1'b1;
    if (a == 2) return 1'b0;
    if (a == 3) return ~v;
    return v;
  endfunction

  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_out = '0;
      m_evt = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        m_th[k]   = 0;
        m_mode[k] = 0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        bit nv;
        nv = m_out[k];
        if (bus.ctrl_rst_i) nv = 1'b0;
        else if (bus.ctrl_active_i && bus.cnt_evt_i) begin
          if (int'(bus.cnt_i) == m_th[k]) nv = do_act(match_tbl[m_mode[k]], nv);
          if (bus.cnt_end_i)              nv = do_act(end_tbl[m_mode[k]], nv);
        end
        m_evt[k] = (nv != m_out[k]);
        m_out[k] = nv;
      end
      if (bus.ctrl_update_i)
        for (int k = 0; k < NUM_CH; k++) begin
          m_th[k]   = int'(bus.cfg_th_i[k*CNT_W +: CNT_W]);
          m_mode[k] = int'(bus.cfg_mode_i[k*3 +: 3]);
        end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk_i);
      if (rstn_i) begin
        chk("model_out", 32'(bus.out_o), 32'(m_out));
        chk("model_out_evt", 32'(bus.out_evt_o), 32'(m_evt));
      end
    end
  endtask

  task automatic cyc(input int c, input bit e, input bit en);
    bus.cnt_i     = c[CNT_W-1:0];
    bus.cnt_evt_i = e;
    bus.cnt_end_i = en;
    @(posedge clk_i);
    #2;
    bus.ctrl_update_i = 1'b0;
    bus.ctrl_rst_i    = 1'b0;
    ev0 += int'(bus.out_evt_o[0]);
  endtask

  task automatic set_ch(input int k, input int th, input int mode);
    bus.cfg_th_i[k*CNT_W +: CNT_W] = th[CNT_W-1:0];
    bus.cfg_mode_i[k*3 +: 3]       = mode[2:0];
  endtask

  task automatic upd();
    bus.ctrl_update_i = 1'b1;
    cyc(0, 1'b0, 1'b0);
  endtask

  task automatic clr();
    bus.ctrl_rst_i = 1'b1;
    cyc(0, 1'b0, 1'b0);
  endtask

  task automatic run_stim();
    int c;
    rstn_i = 1'b0;
    bus.ctrl_active_i = 1'b1;
    bus.ctrl_update_i = 1'b0;
    bus.ctrl_rst_i    = 1'b0;
    bus.cnt_i         = '0;
    bus.cnt_evt_i     = 1'b0;
    bus.cnt_end_i     = 1'b0;
    bus.cfg_th_i      = '0;
    bus.cfg_mode_i    = '1;
    repeat (2) @(posedge clk_i);
    #2;
    chk("reset_out", 32'(bus.out_o), 32'h0);
    chk("reset_out_evt", 32'(bus.out_evt_o), 32'h0);
    rstn_i = 1'b1;

    // set on match 5, clear at end 9
    set_ch(0, 5, 3'b010);
    upd();
    ev0 = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(i, 1'b1, i == 9);
      if (i == 4) chk("sc_before_match", 32'(bus.out_o[0]), 32'h0);
      if (i == 5) chk("sc_after_match", 32'(bus.out_o[0]), 32'h1);
    end
    chk("sc_after_end", 32'(bus.out_o[0]), 32'h0);
    chk("sc_pulses", 32'(ev0), 32'd2);

    // toggle-only, two periods
    set_ch(0, 3, 3'b011);
    upd();
    ev0 = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) cyc(i, 1'b1, i == 7);
      chk("tog_period_out", 32'(bus.out_o[0]), (p == 0) ? 32'h1 : 32'h0);
    end
    chk("tog_pulses", 32'(ev0), 32'd2);

    // simultaneous match and end
    set_ch(0, 7, 3'b001);
    upd();
    ev0 = 0;
    for (int i = 0; i < 8; i++) cyc(i, 1'b1, i == 7);
    chk("tog_clr_simul_out", 32'(bus.out_o[0]), 32'h0);
    chk("tog_clr_simul_pulses", 32'(ev0), 32'd0);
    set_ch(0, 7, 3'b101);
    upd();
    ev0 = 0;
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) cyc(i, 1'b1, i == 7);
    chk("tog_set_simul_out", 32'(bus.out_o[0]), 32'h1);
    chk("tog_set_simul_pulses", 32'(ev0), 32'd1);

    // shadowing: cfg change without update is invisible
    clr();
    set_ch(0, 6, 3'b010);
    upd();
    set_ch(0, 2, 3'b010);
    for (int i = 0; i < 3; i++) cyc(i, 1'b1, 1'b0);
    chk("shadow_no_update", 32'(bus.out_o[0]), 32'h0);
    cyc(0, 1'b1, 1'b0);
    bus.ctrl_update_i = 1'b1;
    cyc(1, 1'b1, 1'b0);
    chk("shadow_update_cycle", 32'(bus.out_o[0]), 32'h0);
    cyc(2, 1'b1, 1'b0);
    chk("shadow_new_th", 32'(bus.out_o[0]), 32'h1);

    // stalled counter and inactive timer
    clr();
    set_ch(0, 4, 3'b010);
    upd();
    cyc(4, 1'b0, 1'b0);
    chk("stall_no_evt", 32'(bus.out_o[0]), 32'h0);
    bus.ctrl_active_i = 1'b0;
    cyc(4, 1'b1, 1'b1);
    chk("inactive_hold", 32'(bus.out_o[0]), 32'h0);
    bus.ctrl_active_i = 1'b1;

    // ctrl_rst with pattern 1010
    set_ch(0, 3, 3'b111);
    set_ch(1, 3, 3'b000);
    set_ch(2, 3, 3'b111);
    set_ch(3, 3, 3'b000);
    upd();
    cyc(3, 1'b1, 1'b0);
    chk("pattern_out", 32'(bus.out_o), 32'hA);
    clr();
    chk("ctrl_rst_out", 32'(bus.out_o), 32'h0);
    chk("ctrl_rst_evt", 32'(bus.out_evt_o), 32'hA);

    // reserved mode never moves
    for (int k = 0; k < NUM_CH; k++) set_ch(k, 0, 3'b111);
    upd();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < NUM_CH; k++) set_ch(k, int'($urandom_range(0, 7)), 3'b111);
      bus.ctrl_update_i = ($urandom_range(0, 3) == 0);
      cyc(int'($urandom_range(0, 7)), 1'b1, $urandom_range(0, 2) == 0);
    end
    chk("rsvd_out", 32'(bus.out_o), 32'h0);

    // async reset mid-period
    set_ch(0, 1, 3'b000);
    upd();
    cyc(1, 1'b1, 1'b0);
    chk("pre_async_out", 32'(bus.out_o[0]), 32'h1);
    #1 rstn_i = 1'b0;
    #1;
    chk("async_rst_out", 32'(bus.out_o), 32'h0);
    chk("async_rst_evt", 32'(bus.out_evt_o), 32'h0);
    @(posedge clk_i);
    #2 rstn_i = 1'b1;

    // randomized traffic
    c = 0;
    for (int i = 0; i < 600; i++) begin
      bit e, en;
      for (int k = 0; k < NUM_CH; k++)
        set_ch(k, int'($urandom_range(0, 13)), int'($urandom_range(0, 7)));
      bus.ctrl_update_i = ($urandom_range(0, 5) == 0);
      bus.ctrl_rst_i    = ($urandom_range(0, 39) == 0);
      bus.ctrl_active_i = ($urandom_range(0, 9) != 0);
      e  = ($urandom_range(0, 3) != 0);
      en = e && (c == 11);
      cyc(c, e, en);
      if (e && bus.ctrl_active_i) c = (c == 11) ? 0 : c + 1;
    end
  endtask

  initial begin
    fork
      compare_loop();
      run_stim();
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
